// File: rtl/mac_feeder_pkg.sv
// Shared widths, defaults and FSM state encoding for the MAC operand feeder.
package mac_feeder_pkg;
  localparam int PIX_W        = 8;
  localparam int LANES        = 16;
  localparam int WORD_W       = PIX_W * LANES;
  localparam int CHUNKS_DEF   = 49;
  localparam int NEURONS_DEF  = 10;
  localparam int PIPE_LAT_DEF = 2;
  localparam int AW_DEF       = 9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_PACK  = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
endpackage

// File: rtl/mac_feeder_pix_packer.sv
// Loads pixel bytes lane by lane into one operand word; strobes when the last lane is written.
module mac_feeder_pix_packer
  import mac_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [PIX_W-1:0]  i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_full
);
  localparam int LW = $clog2(LANES);

  logic [LW-1:0]     r_lane;
  logic [WORD_W-1:0] r_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_load) begin
      r_word[r_lane*PIX_W +: PIX_W] <= i_byte;
      if (r_lane == LW'(LANES-1)) r_lane <= '0;
      else                        r_lane <= r_lane + 1'b1;
    end
  end

  assign o_word      = r_word;
  assign o_word_full = i_load && (r_lane == LW'(LANES-1));
endmodule

// File: rtl/mac_feeder.sv
// Sequences packed pixel words and ROM weight words into one MAC/accumulator neuron.
//   state | meaning
//   IDLE  | waiting for start with a legal neuron index
//   CLEAR | one-cycle accumulator clear
//   PACK  | accepting pixel bytes into the operand word
//   FETCH | weight ROM address presented
//   ISSUE | operands driven to the MAC for one cycle
//   DRAIN | waiting out the datapath pipeline
//   DONE  | sigmoid output valid
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int CHUNKS   = CHUNKS_DEF,
  parameter int NEURONS  = NEURONS_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int AW       = AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        neuron,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [AW-1:0]     w_addr,
  input  logic [WORD_W-1:0] w_data,
  output logic [WORD_W-1:0] pixels,
  output logic [WORD_W-1:0] weights,
  output logic              acc_clr,
  output logic              busy,
  output logic              out_valid
);
  localparam int CW = $clog2(CHUNKS);
  localparam int DW = $clog2(PIPE_LAT) + 1;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [CW-1:0]     r_chunk;
  logic [AW-1:0]     r_base;
  logic [AW-1:0]     r_w_addr;
  logic [DW-1:0]     r_drain;
  logic              r_acc_clr;
  logic              w_neuron_ok;
  logic              w_load;
  logic              w_word_full;
  logic [WORD_W-1:0] w_word;

  assign w_neuron_ok = ({28'd0, neuron} < 32'(NEURONS));
  assign w_load      = (r_state == S_PACK) && pix_valid;

  mac_feeder_pix_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_byte      (pix_in),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && w_neuron_ok) w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = S_PACK;
      S_PACK:  if (w_word_full) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = (r_chunk == CW'(CHUNKS-1)) ? S_DRAIN : S_PACK;
      S_DRAIN: if (r_drain == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_chunk   <= '0;
      r_base    <= '0;
      r_w_addr  <= '0;
      r_drain   <= '0;
      r_acc_clr <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_acc_clr <= (w_state_nxt == S_CLEAR);
      if (r_state == S_IDLE && w_state_nxt == S_CLEAR) begin
        r_base  <= AW'(32'(neuron) * CHUNKS);
        r_chunk <= '0;
      end
      if (r_state == S_ISSUE && w_state_nxt == S_PACK) r_chunk <= r_chunk + 1'b1;
      if (w_state_nxt == S_FETCH) r_w_addr <= r_base + AW'(r_chunk);
      // Down-counter spans the datapath latency; DONE follows its terminal count.
      if (r_state == S_ISSUE && w_state_nxt == S_DRAIN) r_drain <= DW'(PIPE_LAT-1);
      else if (r_state == S_DRAIN)                      r_drain <= r_drain - 1'b1;
    end
  end

  assign pix_ready = (r_state == S_PACK);
  assign w_addr    = r_w_addr;
  assign pixels    = (r_state == S_ISSUE) ? w_word : '0;
  assign weights   = (r_state == S_ISSUE) ? w_data : '0;
  assign acc_clr   = r_acc_clr;
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign out_valid = (r_state == S_DONE);
endmodule
